// File: rtl/l2_arbiter.sv
// Shares the single L2 port between the L1 I-cache and D-cache via registered holding regs.
// Latency: arb_* request one cycle after a request is seen; resp is combinational on L2_resp.
// Backpressure: requesters hold until their resp; a DONE dead cycle follows every transaction.
module l2_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int LINE_W      = 128,
    parameter int DCACHE_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              arb_read,
    output logic              arb_write,
    output logic [ADDR_W-1:0] arb_address,
    output logic [LINE_W-1:0] arb_wdata,
    input  logic              L2_resp,
    input  logic [LINE_W-1:0] arb_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              grant, grant_nxt;
    logic              lrg, lrg_nxt;
    logic              arb_read_nxt, arb_write_nxt;
    logic [ADDR_W-1:0] arb_address_nxt;
    logic [LINE_W-1:0] arb_wdata_nxt;

    logic i_pend, d_pend, pick_d, l2_done;

    assign i_pend  = i_read;
    assign d_pend  = d_read | d_write;
    assign l2_done = (state == BUSY) && L2_resp;

    // grant/lrg encoding: 0 = I-cache, 1 = D-cache, so "not lrg" is simply ~lrg
    always_comb begin
        pick_d = 1'b0;
        if (d_pend && !i_pend) begin
            pick_d = 1'b1;
        end else if (d_pend && i_pend) begin
            pick_d = (DCACHE_PRIO != 0) ? 1'b1 : ~lrg;
        end
    end

    assign i_resp  = l2_done & ~grant;
    assign d_resp  = l2_done & grant;
    assign i_rdata = i_resp ? arb_rdata : '0;
    assign d_rdata = d_resp ? arb_rdata : '0;

    always_comb begin
        state_nxt       = state;
        grant_nxt       = grant;
        lrg_nxt         = lrg;
        arb_read_nxt    = arb_read;
        arb_write_nxt   = arb_write;
        arb_address_nxt = arb_address;
        arb_wdata_nxt   = arb_wdata;

        case (state)
            IDLE: begin
                if (i_pend || d_pend) begin
                    state_nxt       = BUSY;
                    grant_nxt       = pick_d;
                    lrg_nxt         = pick_d;
                    arb_address_nxt = pick_d ? d_address : i_address;
                    // a simultaneous read+write from the D-cache goes out as a write only
                    arb_write_nxt   = pick_d & d_write;
                    arb_read_nxt    = pick_d ? (d_read & ~d_write) : 1'b1;
                    if (pick_d && d_write) begin
                        arb_wdata_nxt = d_wdata;
                    end
                end
            end
            BUSY: begin
                if (L2_resp) begin
                    state_nxt     = DONE;
                    arb_read_nxt  = 1'b0;
                    arb_write_nxt = 1'b0;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt     = IDLE;
                arb_read_nxt  = 1'b0;
                arb_write_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            grant       <= 1'b0;
            lrg         <= 1'b1;
            arb_read    <= 1'b0;
            arb_write   <= 1'b0;
            arb_address <= '0;
            arb_wdata   <= '0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            lrg         <= lrg_nxt;
            arb_read    <= arb_read_nxt;
            arb_write   <= arb_write_nxt;
            arb_address <= arb_address_nxt;
            arb_wdata   <= arb_wdata_nxt;
        end
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// Scoreboarded bench for l2_arbiter: lane 0 is round-robin, lane 1 has D-cache priority.
module tb_l2_arbiter;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
    } req_t;

    typedef struct {
        logic         is_d;
        logic [127:0] data;
    } rsp_t;

    logic clk;
    logic reset_n;

    logic         i_read    [2];
    logic [15:0]  i_address [2];
    logic [127:0] i_rdata   [2];
    logic         i_resp    [2];
    logic         d_read    [2];
    logic         d_write   [2];
    logic [15:0]  d_address [2];
    logic [127:0] d_wdata   [2];
    logic [127:0] d_rdata   [2];
    logic         d_resp    [2];
    logic         arb_read  [2];
    logic         arb_write [2];
    logic [15:0]  arb_address [2];
    logic [127:0] arb_wdata [2];
    logic         l2_resp   [2];
    logic [127:0] l2_rdata  [2];
    logic         spur      [2];
    int           l2_lat    [2];
    logic [127:0] l2_pat    [2];

    req_t exp_req [2][$];
    rsp_t exp_rsp [2][$];

    int n_chk  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] line_of(input logic [15:0] a);
        return {8{a}};
    endfunction

    task automatic push_req(input int k, input logic rd, input logic wr,
                            input logic [15:0] a, input logic [127:0] wd);
        req_t r;
        r.rd = rd; r.wr = wr; r.addr = a; r.wdata = wd;
        exp_req[k].push_back(r);
    endtask

    task automatic push_rsp(input int k, input logic is_d, input logic [127:0] data);
        rsp_t s;
        s.is_d = is_d; s.data = data;
        exp_rsp[k].push_back(s);
    endtask

    task automatic wait_resp(input int k, input logic is_d);
        int n = 0;
        logic seen;
        do begin
            @(negedge clk);
            n++;
            seen = is_d ? d_resp[k] : i_resp[k];
        end while (!seen && n < 300);
        check($sformatf("%0d.resp_within_bound", k), 128'(seen), 128'(1));
    endtask

    task automatic i_txn(input int k, input logic [15:0] a);
        @(posedge clk); #1;
        i_address[k] = a;
        i_read[k]    = 1'b1;
        wait_resp(k, 1'b0);
        @(posedge clk); #1;
        i_read[k] = 1'b0;
    endtask

    task automatic d_txn(input int k, input logic rd, input logic wr,
                         input logic [15:0] a, input logic [127:0] wd);
        @(posedge clk); #1;
        d_address[k] = a;
        d_wdata[k]   = wd;
        d_read[k]    = rd;
        d_write[k]   = wr;
        wait_resp(k, 1'b1);
        @(posedge clk); #1;
        d_read[k]  = 1'b0;
        d_write[k] = 1'b0;
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        l2_arbiter #(.ADDR_W(16), .LINE_W(128), .DCACHE_PRIO(g)) u_dut (
            .clk         (clk),
            .reset_n     (reset_n),
            .i_read      (i_read[g]),
            .i_address   (i_address[g]),
            .i_rdata     (i_rdata[g]),
            .i_resp      (i_resp[g]),
            .d_read      (d_read[g]),
            .d_write     (d_write[g]),
            .d_address   (d_address[g]),
            .d_wdata     (d_wdata[g]),
            .d_rdata     (d_rdata[g]),
            .d_resp      (d_resp[g]),
            .arb_read    (arb_read[g]),
            .arb_write   (arb_write[g]),
            .arb_address (arb_address[g]),
            .arb_wdata   (arb_wdata[g]),
            .L2_resp     (l2_resp[g] | spur[g]),
            .arb_rdata   (l2_rdata[g])
        );

        // L2 model: answers l2_lat cycles after it first sees a request; drives all-ones when idle
        int cnt;
        initial begin
            l2_resp[g]  = 1'b0;
            l2_rdata[g] = '1;
            cnt = 0;
            forever begin
                @(posedge clk); #1;
                if (l2_resp[g]) begin
                    l2_resp[g]  = 1'b0;
                    l2_rdata[g] = '1;
                    cnt = 0;
                end else if (arb_read[g] || arb_write[g]) begin
                    if (cnt >= l2_lat[g]) begin
                        l2_resp[g]  = 1'b1;
                        l2_rdata[g] = (l2_pat[g] != '0) ? l2_pat[g] : line_of(arb_address[g]);
                    end else begin
                        cnt++;
                    end
                end else begin
                    cnt = 0;
                end
            end
        end

        initial begin : mon
            req_t  r;
            rsp_t  s;
            logic  prev_req, prev_resp, now_req, any_resp;
            logic  h_rd, h_wr;
            logic [15:0]  h_addr;
            logic [127:0] h_wdata;
            int    cyc, last_resp;
            prev_req = 1'b0; prev_resp = 1'b0;
            h_rd = 1'b0; h_wr = 1'b0; h_addr = '0; h_wdata = '0;
            cyc = 0; last_resp = -100;
            forever begin
                @(negedge clk);
                cyc++;
                if (!reset_n) begin
                    prev_req  = 1'b0;
                    prev_resp = 1'b0;
                    continue;
                end
                now_req  = arb_read[g] | arb_write[g];
                any_resp = i_resp[g] | d_resp[g];
                if (prev_resp)
                    check($sformatf("%0d.arb_idle_in_done", g), 128'(now_req), 128'(0));
                if (now_req && !prev_req) begin
                    // resp cycle, DONE, IDLE, then the request: three samples apart at minimum
                    check($sformatf("%0d.req_gap_ge3", g), 128'((cyc - last_resp) >= 3), 128'(1));
                    if (exp_req[g].size() == 0) begin
                        check($sformatf("%0d.unexpected_req", g), 128'(1), 128'(0));
                    end else begin
                        r = exp_req[g].pop_front();
                        check($sformatf("%0d.arb_read", g), 128'(arb_read[g]), 128'(r.rd));
                        check($sformatf("%0d.arb_write", g), 128'(arb_write[g]), 128'(r.wr));
                        check($sformatf("%0d.arb_address", g), 128'(arb_address[g]), 128'(r.addr));
                        if (r.wr)
                            check($sformatf("%0d.arb_wdata", g), arb_wdata[g], r.wdata);
                    end
                    h_rd = arb_read[g]; h_wr = arb_write[g];
                    h_addr = arb_address[g]; h_wdata = arb_wdata[g];
                end else if (now_req) begin
                    check($sformatf("%0d.arb_stable", g),
                          128'({arb_read[g], arb_write[g], arb_address[g]} == {h_rd, h_wr, h_addr}
                               && arb_wdata[g] == h_wdata), 128'(1));
                end
                if (any_resp) begin
                    check($sformatf("%0d.resp_exclusive", g), 128'(i_resp[g] & d_resp[g]), 128'(0));
                    if (exp_rsp[g].size() == 0) begin
                        check($sformatf("%0d.unexpected_resp", g), 128'(1), 128'(0));
                    end else begin
                        s = exp_rsp[g].pop_front();
                        check($sformatf("%0d.resp_is_d", g), 128'(d_resp[g]), 128'(s.is_d));
                        check($sformatf("%0d.resp_data", g), s.is_d ? d_rdata[g] : i_rdata[g], s.data);
                        check($sformatf("%0d.other_rdata_zero", g), s.is_d ? i_rdata[g] : d_rdata[g], '0);
                    end
                    last_resp = cyc;
                end else begin
                    check($sformatf("%0d.idle_rdata_zero", g), i_rdata[g] | d_rdata[g], '0);
                end
                prev_req  = now_req;
                prev_resp = any_resp;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            i_read[k] = 1'b0; i_address[k] = '0;
            d_read[k] = 1'b0; d_write[k] = 1'b0; d_address[k] = '0; d_wdata[k] = '0;
            spur[k] = 1'b0; l2_lat[k] = 1; l2_pat[k] = '0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%0d.rst_arb_read", k), 128'(arb_read[k]), 128'(0));
            check($sformatf("%0d.rst_arb_write", k), 128'(arb_write[k]), 128'(0));
            check($sformatf("%0d.rst_arb_address", k), 128'(arb_address[k]), 128'(0));
            check($sformatf("%0d.rst_arb_wdata", k), arb_wdata[k], '0);
            check($sformatf("%0d.rst_resp", k), 128'({i_resp[k], d_resp[k]}), 128'(0));
        end
        @(posedge clk); #2;
        reset_n = 1'b1;

        // I-cache read, L2 answers two cycles after arb_read rises
        l2_lat[0] = 2;
        l2_pat[0] = {16{8'hA5}};
        push_req(0, 1'b1, 1'b0, 16'h1230, '0);
        push_rsp(0, 1'b0, {16{8'hA5}});
        fork
            i_txn(0, 16'h1230);
            begin
                @(posedge clk); #1;
                @(negedge clk);
                check("0.t1_no_req_when_seen", 128'(arb_read[0]), 128'(0));
                @(negedge clk);
                check("0.t1_req_next_cycle", 128'(arb_read[0]), 128'(1));
            end
        join
        l2_pat[0] = '0;

        // D-cache write
        l2_lat[0] = 1;
        push_req(0, 1'b0, 1'b1, 16'h4440, 128'h0123456789ABCDEF0123456789ABCDEF);
        push_rsp(0, 1'b1, line_of(16'h4440));
        d_txn(0, 1'b0, 1'b1, 16'h4440, 128'h0123456789ABCDEF0123456789ABCDEF);

        // round-robin with both requesting back to back, minimum L2 latency
        l2_lat[0] = 0;
        push_req(0, 1'b1, 1'b0, 16'h0100, '0); push_rsp(0, 1'b0, line_of(16'h0100));
        push_req(0, 1'b1, 1'b0, 16'h0200, '0); push_rsp(0, 1'b1, line_of(16'h0200));
        push_req(0, 1'b1, 1'b0, 16'h0110, '0); push_rsp(0, 1'b0, line_of(16'h0110));
        push_req(0, 1'b1, 1'b0, 16'h0210, '0); push_rsp(0, 1'b1, line_of(16'h0210));
        fork
            begin i_txn(0, 16'h0100); i_txn(0, 16'h0110); end
            begin d_txn(0, 1'b1, 1'b0, 16'h0200, '0); d_txn(0, 1'b1, 1'b0, 16'h0210, '0); end
        join

        // D-cache priority: D keeps winning until it stops asking
        l2_lat[1] = 1;
        push_req(1, 1'b1, 1'b0, 16'h5000, '0); push_rsp(1, 1'b1, line_of(16'h5000));
        push_req(1, 1'b1, 1'b0, 16'h5010, '0); push_rsp(1, 1'b1, line_of(16'h5010));
        push_req(1, 1'b1, 1'b0, 16'h6000, '0); push_rsp(1, 1'b0, line_of(16'h6000));
        fork
            begin d_txn(1, 1'b1, 1'b0, 16'h5000, '0); d_txn(1, 1'b1, 1'b0, 16'h5010, '0); end
            i_txn(1, 16'h6000);
        join

        // reset mid-BUSY abandons the transaction; the held I request is granted again
        l2_lat[0] = 4;
        push_req(0, 1'b1, 1'b0, 16'h7770, '0);
        push_req(0, 1'b1, 1'b0, 16'h7770, '0);
        push_rsp(0, 1'b0, line_of(16'h7770));
        fork
            i_txn(0, 16'h7770);
            begin
                int n = 0;
                do begin @(negedge clk); n++; end while (!arb_read[0] && n < 50);
                check("0.rst_wait_req", 128'(arb_read[0]), 128'(1));
                @(posedge clk); #2;
                reset_n = 1'b0;
                #1;
                check("0.async_rst_read", 128'(arb_read[0]), 128'(0));
                check("0.async_rst_write", 128'(arb_write[0]), 128'(0));
                check("0.async_rst_address", 128'(arb_address[0]), 128'(0));
                @(posedge clk); #2;
                reset_n = 1'b1;
            end
        join

        // stray L2_resp while idle must not produce a resp
        l2_lat[0] = 1;
        @(posedge clk); #1;
        spur[0] = 1'b1;
        @(negedge clk);
        check("0.spur_no_i_resp", 128'(i_resp[0]), 128'(0));
        check("0.spur_no_d_resp", 128'(d_resp[0]), 128'(0));
        @(posedge clk); #1;
        spur[0] = 1'b0;

        // read+write together issues as a write
        push_req(0, 1'b0, 1'b1, 16'h9990, 128'hFEDCBA9876543210FEDCBA9876543210);
        push_rsp(0, 1'b1, line_of(16'h9990));
        d_txn(0, 1'b1, 1'b1, 16'h9990, 128'hFEDCBA9876543210FEDCBA9876543210);

        repeat (5) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%0d.exp_req_drained", k), 128'(exp_req[k].size()), 128'(0));
            check($sformatf("%0d.exp_rsp_drained", k), 128'(exp_rsp[k].size()), 128'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
